// File: rtl/median_window_feeder_pkg.sv
// Shared definitions for the median window feeder and the median filter
// that consumes its three channels.
package median_window_feeder_pkg;

  // Default pixel / channel word width.
  localparam int WIDTH_DEF = 32;

  // Frame length: number of windows per frame. This is the same value as
  // the median filter's loop bound, so both sides agree on frame size.
  localparam int MEDIAN_LOOP_LEN = 8533;

  // Default window counter width.
  localparam int CNT_W_DEF = 32;

  // Feeder control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/median_window_feeder_window_shift_reg3.sv
// Two-tap pixel history with enable and synchronous clear. Together with the
// incoming pixel it forms the 3-word window {t-2, t-1, t}.
module window_shift_reg3 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] win0_o,
  output logic [WIDTH-1:0] win1_o,
  output logic [WIDTH-1:0] win2_o
);

  logic [WIDTH-1:0] tap1_q;
  logic [WIDTH-1:0] tap2_q;

  // Shift the newest pixel into tap1 and age tap1 into tap2; clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tap1_q <= '0;
      tap2_q <= '0;
    end else if (clr_i) begin
      tap1_q <= '0;
      tap2_q <= '0;
    end else if (en_i) begin
      tap2_q <= tap1_q;
      tap1_q <= din_i;
    end
  end

  assign win0_o = tap2_q;
  assign win1_o = tap1_q;
  assign win2_o = din_i;

endmodule

// File: rtl/median_window_feeder.sv
// Producer for the three median channels: turns a scalar pixel stream into
// sliding 3-tap windows, one window word per channel, counted per frame.
module median_window_feeder
  import median_window_feeder_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int NUM_WINDOWS = MEDIAN_LOOP_LEN,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [WIDTH-1:0] pix_data,
  output logic [WIDTH-1:0] in0_in_data,
  output logic [WIDTH-1:0] in1_in_data,
  output logic [WIDTH-1:0] in2_in_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_count,
  output logic             done
);

  localparam logic [CNT_W-1:0] NUM_W_C = CNT_W'(NUM_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic             fill_q;       // one pixel already captured in FILL
  logic [CNT_W-1:0] issued_q;     // windows loaded into the output register
  logic [CNT_W-1:0] win_count_q;  // windows accepted downstream
  logic [WIDTH-1:0] in0_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic             win_valid_q;
  logic             done_q;

  logic             pix_ready_d;
  logic             pix_xfer;
  logic             win_xfer;
  logic             shift_clr;
  logic [WIDTH-1:0] win0;
  logic [WIDTH-1:0] win1;
  logic [WIDTH-1:0] win2;

  // Upstream ready: open in FILL; in STREAM only when the output register
  // can take a new window and the frame still needs windows.
  always_comb begin
    pix_ready_d = 1'b0;
    case (state_q)
      ST_FILL:   pix_ready_d = 1'b1;
      ST_STREAM: pix_ready_d = (issued_q != NUM_W_C) && (!win_valid_q || win_ready);
      default:   pix_ready_d = 1'b0;
    endcase
  end

  assign pix_xfer  = pix_valid && pix_ready_d;
  assign win_xfer  = win_valid_q && win_ready;
  assign shift_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  window_shift_reg3 #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (shift_clr),
    .en_i  (pix_xfer),
    .din_i (pix_data),
    .win0_o(win0),
    .win1_o(win1),
    .win2_o(win2)
  );

  // Frame control, counters and the single window output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_q      <= 1'b0;
      issued_q    <= '0;
      win_count_q <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_FILL;
            fill_q      <= 1'b0;
            issued_q    <= '0;
            win_count_q <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
          end
        end
        ST_FILL: begin
          if (pix_xfer) begin
            if (fill_q) begin
              state_q <= ST_STREAM;
              fill_q  <= 1'b0;
            end else begin
              fill_q <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (pix_xfer) begin
            in0_q       <= win0;
            in1_q       <= win1;
            in2_q       <= win2;
            win_valid_q <= 1'b1;
            issued_q    <= issued_q + CNT_ONE;
          end else if (win_xfer) begin
            win_valid_q <= 1'b0;
          end
          if (win_xfer) begin
            win_count_q <= win_count_q + CNT_ONE;
            // Last window accepted: no pixel can transfer in this cycle
            // because ready is already closed once all windows are issued.
            if ((win_count_q + CNT_ONE) == NUM_W_C) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              win_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pix_ready   = pix_ready_d;
  assign in0_in_data = in0_q;
  assign in1_in_data = in1_q;
  assign in2_in_data = in2_q;
  assign win_valid   = win_valid_q;
  assign win_count   = win_count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench: a 4-window instance for the protocol scenarios and a
// default-length instance for the full frame.
module tb_median_window_feeder;

  localparam int W  = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          s_start, s_pv, s_pr, s_wv, s_wr, s_done;
  logic [W-1:0]  s_pd, s_in0, s_in1, s_in2;
  logic [CW-1:0] s_cnt;

  logic          b_start, b_pv, b_pr, b_wv, b_wr, b_done;
  logic [W-1:0]  b_pd, b_in0, b_in1, b_in2;
  logic [CW-1:0] b_cnt;

  int n_run  = 0;
  int n_fail = 0;

  median_window_feeder #(.WIDTH(W), .NUM_WINDOWS(4), .CNT_W(CW)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .pix_valid(s_pv), .pix_ready(s_pr),
    .pix_data(s_pd), .in0_in_data(s_in0), .in1_in_data(s_in1), .in2_in_data(s_in2),
    .win_valid(s_wv), .win_ready(s_wr), .win_count(s_cnt), .done(s_done)
  );

  median_window_feeder #(.WIDTH(W), .CNT_W(CW)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .pix_valid(b_pv), .pix_ready(b_pr),
    .pix_data(b_pd), .in0_in_data(b_in0), .in1_in_data(b_in1), .in2_in_data(b_in2),
    .win_valid(b_wv), .win_ready(b_wr), .win_count(b_cnt), .done(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c);
    chk({tag, ".in0"}, 64'(s_in0), 64'(a));
    chk({tag, ".in1"}, 64'(s_in1), 64'(b));
    chk({tag, ".in2"}, 64'(s_in2), 64'(c));
    chk({tag, ".wv"},  64'(s_wv),  64'd1);
  endtask

  task automatic start_small();
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
  endtask

  // Back-to-back frame of pixels 1..6 with win_ready high; start is pulsed
  // alongside pixel start_at (0 = never).
  task automatic small_frame_b2b(input string tag, input int start_at);
    for (int k = 1; k <= 6; k++) begin
      if (k >= 4) chk_win({tag, ".win"}, k - 3, k - 2, k - 1);
      s_pv = 1'b1; s_pd = W'(k); s_start = (k == start_at);
      #1 chk({tag, ".pr"}, 64'(s_pr), 64'd1);
      @(negedge clk);
    end
    s_start = 1'b0;
    chk_win({tag, ".win"}, 4, 5, 6);
    chk({tag, ".cnt3"}, 64'(s_cnt), 64'd3);
    s_pv = 1'b0;
    #1 chk({tag, ".pr_full"}, 64'(s_pr), 64'd0);
    @(negedge clk);
    s_pv = 1'b1;
    #1;
    chk({tag, ".done"}, 64'(s_done), 64'd1);
    chk({tag, ".cnt4"}, 64'(s_cnt), 64'd4);
    chk({tag, ".wv_done"}, 64'(s_wv), 64'd0);
    chk({tag, ".pr_done"}, 64'(s_pr), 64'd0);
    s_pv = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_pv = 1'b0; s_pd = '0; s_wr = 1'b1;
    b_start = 1'b0; b_pv = 1'b0; b_pd = '0; b_wr = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst.in0", 64'(s_in0), 64'd0);
    chk("rst.in1", 64'(s_in1), 64'd0);
    chk("rst.in2", 64'(s_in2), 64'd0);
    chk("rst.wv", 64'(s_wv), 64'd0);
    chk("rst.pr", 64'(s_pr), 64'd0);
    chk("rst.done", 64'(s_done), 64'd0);
    chk("rst.cnt", 64'(s_cnt), 64'd0);
    rst = 1'b0;

    // 1: back-to-back frame
    s_pv = 1'b1;
    #1 chk("idle.pr", 64'(s_pr), 64'd0);
    s_pv = 1'b0;
    start_small();
    small_frame_b2b("b2b", 0);

    // 2: backpressure after the first window
    start_small();
    for (int k = 1; k <= 3; k++) begin
      s_pv = 1'b1; s_pd = W'(k);
      @(negedge clk);
    end
    s_wr = 1'b0; s_pd = W'(4);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_win("bp.hold", 1, 2, 3);
      chk("bp.pr", 64'(s_pr), 64'd0);
      chk("bp.cnt", 64'(s_cnt), 64'd0);
      @(negedge clk);
    end
    s_wr = 1'b1;
    #1 chk("bp.pr_rel", 64'(s_pr), 64'd1);
    @(negedge clk);
    chk_win("bp.next", 2, 3, 4);
    chk("bp.cnt1", 64'(s_cnt), 64'd1);
    s_pd = W'(5);
    @(negedge clk);
    chk_win("bp.w3", 3, 4, 5);
    s_pd = W'(6);
    @(negedge clk);
    chk_win("bp.w4", 4, 5, 6);
    s_pv = 1'b0;
    @(negedge clk);
    chk("bp.done", 64'(s_done), 64'd1);
    chk("bp.cnt4", 64'(s_cnt), 64'd4);

    // 3: gapped input
    start_small();
    for (int k = 1; k <= 6; k++) begin
      chk("gap.idle_wv", 64'(s_wv), 64'd0);
      s_pv = 1'b1; s_pd = W'(k);
      @(negedge clk);
      s_pv = 1'b0;
      if (k >= 3) begin
        chk_win("gap.win", k - 2, k - 1, k);
        chk("gap.cnt", 64'(s_cnt), 64'(k - 3));
      end else begin
        chk("gap.fill_wv", 64'(s_wv), 64'd0);
      end
      @(negedge clk);
    end
    chk("gap.done", 64'(s_done), 64'd1);
    chk("gap.cnt4", 64'(s_cnt), 64'd4);

    // 4: asynchronous reset mid-STREAM, then a fresh frame
    start_small();
    for (int k = 1; k <= 4; k++) begin
      s_pv = 1'b1; s_pd = W'(k);
      @(negedge clk);
    end
    chk_win("mr.pre", 2, 3, 4);
    s_pv = 1'b0;
    @(negedge clk);
    chk("mr.cnt2", 64'(s_cnt), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("mr.in0", 64'(s_in0), 64'd0);
    chk("mr.in1", 64'(s_in1), 64'd0);
    chk("mr.in2", 64'(s_in2), 64'd0);
    chk("mr.wv", 64'(s_wv), 64'd0);
    chk("mr.cnt", 64'(s_cnt), 64'd0);
    chk("mr.pr", 64'(s_pr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_small();
    for (int k = 10; k <= 12; k++) begin
      s_pv = 1'b1; s_pd = W'(k);
      @(negedge clk);
    end
    chk_win("mr.first", 10, 11, 12);
    chk("mr.cnt0", 64'(s_cnt), 64'd0);
    for (int k = 13; k <= 15; k++) begin
      s_pd = W'(k);
      @(negedge clk);
      chk_win("mr.win", k - 2, k - 1, k);
      chk("mr.cnt", 64'(s_cnt), 64'(k - 12));
    end
    s_pv = 1'b0;
    @(negedge clk);
    chk("mr.done", 64'(s_done), 64'd1);

    // 5: start pulses during FILL and STREAM are ignored
    start_small();
    small_frame_b2b("ign", 4);
    start_small();
    small_frame_b2b("ign_fill", 1);

    // 6: default-length frame, pixels 0..8534
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int k = 0; k <= 8534; k++) begin
      if (k == 100) begin
        chk("big.mid_in0", 64'(b_in0), 64'd97);
        chk("big.mid_in2", 64'(b_in2), 64'd99);
      end
      b_pv = 1'b1; b_pd = W'(k);
      @(negedge clk);
    end
    b_pv = 1'b0;
    chk("big.in0", 64'(b_in0), 64'd8532);
    chk("big.in1", 64'(b_in1), 64'd8533);
    chk("big.in2", 64'(b_in2), 64'd8534);
    chk("big.wv", 64'(b_wv), 64'd1);
    chk("big.cnt_pre", 64'(b_cnt), 64'd8532);
    @(negedge clk);
    chk("big.done", 64'(b_done), 64'd1);
    chk("big.cnt", 64'(b_cnt), 64'd8533);
    chk("big.pr", 64'(b_pr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
